// File: rtl/tc_pkg.sv
// Shared definitions for the timer/counter peripheral: FSM states, register
// offsets, CTRL fields and the byte-lane merge used by bus-attached blocks.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    // Replace each byte lane whose enable is set; keep the others.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// registered interrupt. Define TC_COUNT_WR_EN to make COUNT bus-writable.
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        hit, wr, wr_ctrl, wr_preset;
    logic [3:0]  offset;
    logic        en;
    logic        load_count, dec_count, expire, int_clr_en, int_clr_flag;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign offset    = {addr[3:2], 2'b00};
    assign hit       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign wr        = hit && (byteen != 4'b0000);
    assign wr_ctrl   = wr && (offset == OFF_CTRL);
    assign wr_preset = wr && (offset == OFF_PRESET);
    assign en        = ctrl_q[CTRL_EN];

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   rdata = {28'b0, ctrl_q};
                OFF_PRESET: rdata = preset_q;
                OFF_COUNT:  rdata = count_q;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = LOAD;
            LOAD: state_d = CNT;
            CNT: begin
                if (!en)                 state_d = IDLE;
                else if (count_q <= 32'd1) state_d = INT;
            end
            INT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_count   = 1'b0;
        dec_count    = 1'b0;
        expire       = 1'b0;
        int_clr_en   = 1'b0;
        int_clr_flag = 1'b0;
        case (state_q)
            LOAD: load_count = 1'b1;
            CNT: begin
                if (en) begin
                    if (count_q > 32'd1) dec_count = 1'b1;
                    else                 expire    = 1'b1;
                end
            end
            INT: begin
                if (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD) int_clr_flag = 1'b1;
                else                                           int_clr_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // Bus writes take priority over the FSM's own register updates.
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (wr_ctrl) begin
            if (byteen[0]) ctrl_d = wdata[3:0];
        end else if (int_clr_en) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end

        if (wr_preset) preset_d = byte_merge(preset_q, wdata, byteen);

        if (load_count)     count_d = preset_q;
        else if (dec_count) count_d = count_q - 32'd1;
        else if (expire)    count_d = '0;
`ifdef TC_COUNT_WR_EN
        if (wr && (offset == OFF_COUNT)) count_d = byte_merge(count_q, wdata, byteen);
`endif

        if (expire)                flag_d = 1'b1;
        if (int_clr_flag)          flag_d = 1'b0;
        if (wr_ctrl || wr_preset)  flag_d = 1'b0;
    end

    // irq is registered from the next-state flag and mask so it tracks them with no extra lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq      <= flag_d & ctrl_d[CTRL_IM];
        end
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped timer/counter peripheral on the CPU data bus, one level below the system bridge. It answers word and byte-enabled accesses from the CPU's M-stage data port and drives the CPU's `interrupt` input, which the simulation bench otherwise holds low. It is the interrupt source that exercises the exception handler at 0x4180.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: base of the 16-byte register window; bits [3:0] must be 0.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `addr` input 32: byte address from the bridge; bits [1:0] are ignored.
- `byteen` input 4: write byte enables; 4'b0000 means no write.
- `wdata` input 32: write data, already lane-aligned by the CPU.
- `rdata` output 32: read data, combinational from `addr`.
- `irq` output 1: interrupt request to the CPU, registered.

## Operation
- Hit: `addr[31:4] == BASE_ADDR[31:4]` and `addr[3:2] != 2'b11`. A miss, or offset 0xC, reads 0 and ignores writes.
- Registers:
  - 0x0 CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask). Bits[31:4] read 0.
  - 0x4 PRESET.
  - 0x8 COUNT, read-only (see Configuration).
- Writes merge per byte: each lane with `byteen[i]` set replaces byte i; other bytes are kept.
- State machine:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE and hold COUNT.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else COUNT <= 0, set flag, go to INT.
  - INT:
    - MODE 00: EN <= 0 and flag stays set.
    - MODE 01: flag cleared.
    - Both modes then go to IDLE.
- `irq = flag & IM`, registered.
- A write hitting CTRL or PRESET clears the flag.
- Simultaneous events: a bus write to CTRL in the same cycle as the INT-state clear of EN wins; the written EN value is kept.
- PRESET written while counting takes effect at the next LOAD only.
- EN cleared mid-count: the next edge goes to IDLE. Re-enabling goes through LOAD and restarts from PRESET.
- All 32-bit arithmetic is unsigned with no wrap. COUNT never decrements below 0.

## Timing
- Reset values: CTRL, PRESET, COUNT, flag and `irq` are all 0; state is IDLE.
- A write takes effect at the edge where it is presented with `byteen != 0`.
- A read returns the current register value in the same cycle, with no wait states.
- Latency: with PRESET = N, `irq` rises max(N,1)+2 edges after the edge that writes EN=1. This assumes IM=1 and that PRESET was written beforehand.
- MODE 01: `irq` is high for exactly 1 cycle, with period max(N,1)+3 cycles.
- MODE 00: `irq` stays high until CTRL or PRESET is written, or reset is asserted.
- Reset mid-count returns everything to the reset values at that edge. No pending interrupt survives reset.

## Configuration
- `TC_COUNT_WR_EN` defined: COUNT at 0x8 is writable with the byte merge.
  - A write in CNT replaces the value the FSM would have loaded.
  - Counting continues from the written value at the following edge.
- Not defined: writes to 0x8 are ignored, and COUNT changes only through the FSM.

## Structure
- Shared package `tc_pkg` holds:
  - the state enum (IDLE, LOAD, CNT, INT),
  - register offsets (0x0/0x4/0x8),
  - MODE constants,
  - CTRL bit positions,
  - a byte-merge function (old, new, byteen) for reuse by the bridge and data memory.
- No sub-module. The register file, decode and FSM stay in one module.

## Test plan
- Reset with every input at 0 -> `rdata` is 0 at 0x7F00/04/08, `irq` is 0, state is IDLE.
- One-shot:
  - Stimulus: write PRESET=3, then CTRL=0x9.
  - Response: COUNT reads 3,2,1,0 on successive cycles after LOAD; `irq` rises 5 edges after the CTRL write and stays high; CTRL then reads 0x8.
  - Writing PRESET then drops `irq` at the next edge.
- Auto-reload: PRESET=2, CTRL=0xB -> `irq` 1-cycle pulses every 5 cycles for at least 3 periods. With IM=0 (CTRL=0x3) -> no pulse ever.
- Byte writes:
  - PRESET=0x11223344, then byteen 4'b0010 with wdata 0x0000AA00 -> PRESET reads 0x1122AA44.
  - Writes to 0x7F0C and 0x7F10 -> no register changes.
- Mid-operation:
  - EN cleared at COUNT=5 -> COUNT holds 5 with no `irq`.
  - Reset asserted while `irq` is high -> `irq`=0 at the next edge.
  - Same-cycle CTRL write of 0x9 during INT in mode 00 -> EN stays 1 and a new LOAD follows.
- With `TC_COUNT_WR_EN` defined: during counting, write COUNT=7 -> COUNT reads 7 then 6, and `irq` arrives 7 edges after the write. Without the macro: the write is ignored.
